// File: rtl/reg_bus_master.sv
// ============================================================================
// Module      : reg_bus_master
// Description : Host-side initiator for the board register bus. Accepts
//               quadlet read/write commands, drives the register-file
//               address/data/strobe lines, captures read data after a fixed
//               latency and returns it over a valid/ready response channel.
//               Optional macro REG_MASTER_BURST_EN enables multi-beat reads
//               (cmd_len+1 beats at incrementing addresses).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bus_master #(
    parameter int unsigned READ_LAT = 2   // legal range 1..7
) (
    input  logic        sysclk,
    input  logic        reset,            // synchronous, active low
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last,
    output logic [15:0] reg_raddr,
    output logic [15:0] reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        reg_wen,
    input  logic [31:0] reg_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WGAP  = 3'd2,
        S_RADDR = 3'd3,
        S_RWAIT = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] C_LAT_LOAD = 3'(READ_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_lat_cnt;
    logic [2:0]  w_lat_dec;
    logic        w_accept;
    logic        w_capture;
    logic        w_rsp_fire;
    logic        w_more;
    logic [15:0] r_raddr;
    logic [15:0] r_waddr;
    logic [31:0] r_wdata;
    logic [15:0] r_rsp_addr;
    logic [31:0] r_rsp_data;

`ifdef REG_MASTER_BURST_EN
    // Beats still to be issued after the current one.
    logic [3:0]  r_beats_left;
    assign w_more = (r_beats_left != 4'd0);
`else
    // Single-beat reads only: the burst length field has no effect.
    logic        w_unused_len;
    assign w_unused_len = ^cmd_len;
    assign w_more       = 1'b0;
`endif

    assign w_lat_dec = r_lat_cnt - 3'd1;

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_write ? S_WRITE : S_RADDR;
                end
            end
            S_WRITE: w_state_nxt = S_WGAP;
            S_WGAP:  w_state_nxt = S_IDLE;
            S_RADDR: begin
                // A one-cycle latency leaves no room for a wait cycle, so the
                // data is taken directly while the address is presented.
                if (READ_LAT == 1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (w_lat_dec == 3'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = w_more ? S_RADDR : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, latency counter, read address stepping and capture.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_raddr      <= 16'h0000;
            r_waddr      <= 16'h0000;
            r_wdata      <= 32'h0000_0000;
            r_rsp_addr   <= 16'h0000;
            r_rsp_data   <= 32'h0000_0000;
            r_lat_cnt    <= 3'd0;
`ifdef REG_MASTER_BURST_EN
            r_beats_left <= 4'd0;
`endif
        end else begin
            if (w_accept) begin
                if (cmd_write) begin
                    r_waddr <= cmd_addr;
                    r_wdata <= cmd_wdata;
                end else begin
                    r_raddr <= cmd_addr;
`ifdef REG_MASTER_BURST_EN
                    r_beats_left <= cmd_len;
`endif
                end
            end

            if (r_state == S_RADDR) begin
                r_lat_cnt <= C_LAT_LOAD;
            end else if (r_state == S_RWAIT) begin
                r_lat_cnt <= w_lat_dec;
            end

            if (w_capture) begin
                r_rsp_data <= reg_rdata;
                r_rsp_addr <= r_raddr;
            end

            // Next beat address wraps modulo 2^16.
            if (w_rsp_fire && w_more) begin
                r_raddr <= r_raddr + 16'd1;
`ifdef REG_MASTER_BURST_EN
                r_beats_left <= r_beats_left - 4'd1;
`endif
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE) & reset;
    assign busy      = (r_state != S_IDLE);
    assign reg_wen   = (r_state == S_WRITE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_last  = (r_state == S_RESP) & ~w_more;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign reg_raddr = r_raddr;
    assign reg_waddr = r_waddr;
    assign reg_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/reg_bus_master.md
# reg_bus_master

Host-side initiator for the board register bus. It accepts quadlet read and write commands from a packet parser (FireWire or Ethernet front end) and drives `reg_raddr`, `reg_waddr`, `reg_wdata` and `reg_wen` toward the register-file responders, such as the board, DAC and encoder register files. It captures `reg_rdata` after a fixed read latency and returns read data through a valid/ready response channel. One transaction is in flight at a time.

## Interface
- `READ_LAT`, 2: cycles from `reg_raddr` driven to `reg_rdata` valid; legal range 1–7.
- `sysclk` in 1: system clock (49.152 MHz).
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: master can accept a command.
- `cmd_write` in 1: 1 = quadlet write, 0 = read.
- `cmd_addr` in 16: register address.
- `cmd_wdata` in 32: write data.
- `cmd_len` in 4: read burst length minus 1 (see Configuration).
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: captured read data.
- `rsp_addr` out 16: address the data came from.
- `rsp_last` out 1: final beat of the burst.
- `reg_raddr` out 16: register read address.
- `reg_waddr` out 16: register write address.
- `reg_wdata` out 32: register write data.
- `reg_wen` out 1: write strobe, one cycle per write.
- `reg_rdata` in 32: read data from the responders.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, WGAP, RADDR, RWAIT, RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, latch `cmd_*`.
  - Go to WRITE if `cmd_write`, otherwise RADDR.
- **WRITE**
  - `reg_wen` = 1, `reg_waddr` = latched address, `reg_wdata` = latched data, for exactly one cycle.
  - Then go to WGAP.
- **WGAP**
  - One cycle with `reg_wen` = 0. Responders clear their self-resetting pulse bits during a non-write cycle.
  - Then go to IDLE.
- **RADDR**
  - `reg_raddr` = current address.
  - Load the latency counter with `READ_LAT-1`.
  - Go to RWAIT.
- **RWAIT**
  - Hold `reg_raddr` and keep `reg_wen` = 0.
  - Decrement the counter. At 0, capture `reg_rdata` into `rsp_data`, set `rsp_addr` to the current address, and go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_data`, `rsp_addr` and `rsp_last` are held stable until `rsp_ready`.
  - On `rsp_ready`: if beats remain, increment the address and go to RADDR; otherwise go to IDLE.
- Address increment is 16-bit modulo: 0xFFFF goes to 0x0000.
- `reg_wen` is never asserted outside WRITE. A read is never overlapped with a write.
- `reg_raddr` and `reg_waddr` hold their last values when unused.

## Timing
- Reset values: `cmd_ready`=0 while `reset`=0, `rsp_valid`=0, `rsp_last`=0, `reg_wen`=0, `busy`=0, and all address/data outputs = 0. The FSM is in IDLE.
  - `cmd_ready`=1 on the first cycle after `reset` returns high.
- Write latency: command accepted at cycle N, `reg_wen` high at N+1, `cmd_ready` high again at N+3.
- Read latency: accepted at N, `reg_raddr` valid from N+1, `rsp_valid` at N+1+`READ_LAT`.
- Each further burst beat adds `READ_LAT`+1 cycles plus any `rsp_ready` stall.
- `rsp_ready` already high when `rsp_valid` rises: the beat completes in one cycle.
- `cmd_valid` is ignored while `cmd_ready`=0. No command buffering.
- Reset asserted in any state: on the next edge go to IDLE with all outputs at reset values. Any pending response is dropped, and no `reg_wen` is issued.

## Configuration
- `REG_MASTER_BURST_EN` defined:
  - Reads issue `cmd_len`+1 beats (1–16) at incrementing addresses.
  - `rsp_last` = 1 only on the final beat.
- Not defined:
  - `cmd_len` is ignored and every read is a single beat.
  - `rsp_last` = 1 whenever `rsp_valid` = 1.
  - The beat counter logic is removed.
- Writes are single-quadlet in both builds.

## Test plan
- Reset sequence: hold `reset`=0 for 5 cycles with `cmd_valid`=1.
  - Required: no `reg_wen`, `cmd_ready`=0 throughout, `cmd_ready`=1 on the first cycle after release.
- Write `cmd_addr`=0x0000, `cmd_wdata`=0x000C0000.
  - Required: exactly one `reg_wen` cycle with matching `reg_waddr`/`reg_wdata` at N+1, `reg_wen`=0 at N+2, `cmd_ready`=1 at N+3.
- Read 0x0001 with `READ_LAT`=2, model returning 0x44514C41, `rsp_ready`=1.
  - Required: `rsp_valid` at N+3, `rsp_data`=0x44514C41, `rsp_addr`=0x0001, `rsp_last`=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles.
  - Required: `rsp_valid` and `rsp_data` held stable, `cmd_ready`=0, `reg_wen`=0.
  - After release: IDLE on the next cycle.
- Burst (`REG_MASTER_BURST_EN`): read `cmd_addr`=0xFFFE, `cmd_len`=3.
  - Required: beats from 0xFFFE, 0xFFFF, 0x0000, 0x0001; `rsp_last` only on the 4th.
  - Without the macro: a single beat with `rsp_last`=1.
- Reset asserted during RWAIT.
  - Required: no `rsp_valid`; outputs at reset values on the next edge; a following read completes normally.
